// File: rtl/cross_bar_pkg.sv
// Shared types and helpers for the crossbar master-side request router.
package cross_bar_pkg;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdIssue = 2'd1,
    StWrWait  = 2'd2
  } router_state_e;

  // Slave-select width; a single slave still needs a one-bit select.
  function automatic int unsigned sel_w(input int unsigned slave_num);
    return (slave_num > 1) ? $clog2(slave_num) : 1;
  endfunction

endpackage

// File: rtl/router_tag_fifo.sv
// In-order tag FIFO: remembers which slave each outstanding read went to.
module router_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DepthCnt);
  assign head  = mem_q[rptr_q];

  // Push into a full FIFO is legal only alongside a pop of the same slot.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Next-state: pointers wrap naturally at power-of-two depth.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = push_tag;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/master_req_router.sv
// Master-side request router: decodes the target slave from the address MSBs,
// issues reads into arbiter read FIFOs and writes via valid/ready, and returns
// read responses to the master in issue order.
module master_req_router
  import cross_bar_pkg::*;
#(
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned SLAVE_NUM       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          m_req,
  input  logic                          m_cmd,
  input  logic [AWIDTH-1:0]             m_addr,
  input  logic [DWIDTH-1:0]             m_wdata,
  output logic                          m_ack,
  output logic                          m_resp,
  output logic [DWIDTH-1:0]             m_rdata,
  output logic [SLAVE_NUM-1:0]          rd_wren,
  output logic [AWIDTH-1:0]             rd_addr,
  input  logic [SLAVE_NUM-1:0]          fifo_full,
  output logic [SLAVE_NUM-1:0]          wr_valid,
  output logic [AWIDTH-1:0]             wr_addr,
  output logic [DWIDTH-1:0]             wr_data,
  input  logic [SLAVE_NUM-1:0]          wr_ready,
  input  logic [SLAVE_NUM-1:0]          resp_valid,
  input  logic [SLAVE_NUM*DWIDTH-1:0]   resp_data,
  output logic [SLAVE_NUM-1:0]          resp_ready
);

  localparam int unsigned SEL_W = sel_w(SLAVE_NUM);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  router_state_e     state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              m_resp_q, m_resp_d;
  logic [DWIDTH-1:0] m_rdata_q, m_rdata_d;

  logic [SEL_W-1:0]  req_sel;
  logic              tag_push, tag_pop;
  logic [SEL_W-1:0]  tag_head;
  logic              tag_empty, tag_full;
  logic [DWIDTH-1:0] head_data;

  assign req_sel = m_addr[AWIDTH-1 -: SEL_W];

  // Request FSM: capture on accept, then drive one read push or hold a write.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    m_ack    = 1'b0;
    rd_wren  = '0;
    wr_valid = '0;
    tag_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          if (cmd_e'(m_cmd) == CMD_WR) begin
            state_d = StWrWait;
            addr_d  = m_addr;
            wdata_d = m_wdata;
            sel_d   = req_sel;
          end else if (!fifo_full[req_sel] && (count_q < MaxCnt)) begin
            state_d = StRdIssue;
            addr_d  = m_addr;
            sel_d   = req_sel;
          end
        end
      end
      StRdIssue: begin
        rd_wren[sel_q] = 1'b1;
        m_ack          = 1'b1;
        tag_push       = 1'b1;
        state_d        = StIdle;
      end
      StWrWait: begin
        wr_valid[sel_q] = 1'b1;
        if (wr_ready[sel_q]) begin
          m_ack   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr = addr_q;
  assign wr_addr = addr_q;
  assign wr_data = wdata_q;

  // Only the slave at the head of the tag FIFO may hand back its response.
  always_comb begin
    resp_ready = '0;
    head_data  = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (!tag_empty && (tag_head == SEL_W'(i))) begin
        resp_ready[i] = 1'b1;
        head_data     = resp_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign tag_pop = |(resp_valid & resp_ready);

  // Outstanding count and registered response toward the master.
  always_comb begin
    case ({tag_push, tag_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    m_resp_d  = tag_pop;
    m_rdata_d = tag_pop ? head_data : m_rdata_q;
  end

  assign m_resp  = m_resp_q;
  assign m_rdata = m_rdata_q;

  // State registers; reset drops everything in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      m_resp_q  <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      m_resp_q  <= m_resp_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  router_tag_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (tag_push),
    .push_tag (sel_q),
    .pop      (tag_pop),
    .head     (tag_head),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  a_rd_onehot: assert property (@(posedge aclk) disable iff (areset) $onehot0(rd_wren));
  a_wr_onehot: assert property (@(posedge aclk) disable iff (areset) $onehot0(wr_valid));
  a_rd_wr_excl: assert property (@(posedge aclk) disable iff (areset)
                                 !((|rd_wren) && (|wr_valid)));
  a_no_empty_pop: assert property (@(posedge aclk) disable iff (areset)
                                   !(tag_pop && tag_empty));
  a_no_overflow: assert property (@(posedge aclk) disable iff (areset)
                                  !(tag_push && tag_full && !tag_pop));

endmodule

// File: doc/master_req_router.md
Name: master_req_router

Overview:
- Master-side stage directly upstream of the per-slave arbiters.
- Accepts one master's read/write requests, decodes the target slave from the address MSBs, and issues requests to that slave:
  - reads as a one-cycle write-enable into the arbiter's read-request FIFO;
  - writes as a valid/ready handshake on the arbiter's write-request port.
- Tracks outstanding reads in order and returns read responses to the master in issue order.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- SLAVE_NUM, 2, number of slaves/arbiters; power of two, >= 2.
- MAX_OUTSTANDING, 4, maximum reads in flight; power of two, >= 2.
- SEL_W, $clog2(SLAVE_NUM), derived local; slave-select width.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- m_req  in  1  master request valid.
- m_cmd  in  1  0 = read, 1 = write.
- m_addr  in  AWIDTH  request address.
- m_wdata  in  DWIDTH  write data.
- m_ack  out  1  one-cycle pulse: request accepted.
- m_resp  out  1  one-cycle pulse: read data valid.
- m_rdata  out  DWIDTH  read data, valid when m_resp = 1.
- rd_wren  out  SLAVE_NUM  one-hot push into the target arbiter's read FIFO.
- rd_addr  out  AWIDTH  read address, common to all slaves.
- fifo_full  in  SLAVE_NUM  per-arbiter read-FIFO full.
- wr_valid  out  SLAVE_NUM  one-hot write request.
- wr_addr  out  AWIDTH  write address.
- wr_data  out  DWIDTH  write data.
- wr_ready  in  SLAVE_NUM  per-arbiter write accept.
- resp_valid  in  SLAVE_NUM  per-slave read response valid.
- resp_data  in  SLAVE_NUM*DWIDTH  per-slave read data; slice i = slave i.
- resp_ready  out  SLAVE_NUM  per-slave response accept.

Behaviour:
- Reset (async, while areset = 1):
  - Outputs: m_ack, m_resp, rd_wren, wr_valid, resp_ready = 0; m_rdata, rd_addr, wr_addr, wr_data = 0.
  - State: FSM = IDLE, outstanding count = 0, tag FIFO empty.
  - Any in-flight transaction is dropped; no response is produced after reset is released.
- Slave decode: sel = m_addr[AWIDTH-1 -: SEL_W].
- FSM states: IDLE, RD_ISSUE, WR_WAIT.
- IDLE:
  - m_req & m_cmd = 0 & !fifo_full[sel] & count < MAX_OUTSTANDING -> RD_ISSUE.
  - m_req & m_cmd = 1 -> WR_WAIT.
  - A read blocked by full or by count = MAX_OUTSTANDING stays in IDLE and re-evaluates every cycle; no ack is given.
- RD_ISSUE (exactly 1 cycle):
  - rd_wren[sel] = 1, rd_addr = registered address, m_ack = 1.
  - Push sel into the tag FIFO; count + 1.
  - -> IDLE.
  - Read issue latency: request seen in IDLE at cycle N -> wren and ack at N+1.
- WR_WAIT:
  - wr_valid[sel] = 1 with address and data registered on entry; held stable until wr_ready[sel].
  - On the handshake cycle: m_ack = 1, -> IDLE; wr_valid drops the next cycle.
  - Writes consume no tag.
- Master rule: m_req, m_cmd, m_addr and m_wdata are held until m_ack.
- Response path (runs independently of the FSM):
  - resp_ready[i] = 1 only when the tag FIFO is non-empty and head tag = i.
  - On resp_valid[head] & resp_ready[head]: pop the tag FIFO, count - 1; next cycle m_resp = 1 and m_rdata = resp_data slice[head].
  - Responses from non-head slaves are stalled (ready = 0), which enforces in-order return.
- Simultaneous issue and retire in one cycle: count unchanged; FIFO push and pop are both legal, including when the FIFO is full.
- Tag FIFO pointers wrap modulo MAX_OUTSTANDING.
- Count width is $clog2(MAX_OUTSTANDING)+1; the count never exceeds MAX_OUTSTANDING.
- Assertions:
  - rd_wren and wr_valid are each one-hot or zero.
  - rd_wren and wr_valid are never nonzero in the same cycle.
  - No pop from an empty tag FIFO.

Decomposition:
- Package cross_bar_pkg:
  - cmd_e enum (CMD_RD = 0, CMD_WR = 1).
  - router_state_e enum.
  - sel_w(SLAVE_NUM) function.
- Sub-module router_tag_fifo: synchronous FIFO, width SEL_W, depth MAX_OUTSTANDING, ports push/pop/head/empty/full, async active-high reset.

Test Plan:
- Read to 0x8000_0010 (SLAVE_NUM = 2), fifo_full = 0 -> rd_wren = 2'b10 and m_ack one cycle later, rd_addr = 0x8000_0010; resp_valid[1] with data 0xCAFE -> m_resp next cycle, m_rdata = 0xCAFE.
- fifo_full[0] = 1 for 5 cycles, then read to 0x0000_0004 -> no wren or ack while full; rd_wren = 2'b01 one cycle after full drops.
- Write 0x0000_0020 / 0x1234 with wr_ready[0] low for 3 cycles -> wr_valid[0] held 4 cycles, data stable; m_ack on the handshake cycle only.
- Reads to slave 1 then slave 0; slave 0 responds first -> resp_ready[0] = 0 until slave 1 responds; m_rdata order = slave 1 data, then slave 0 data.
- 4 reads issued with no responses -> 5th read stalls with no ack; one response frees a slot -> 5th issues; same-cycle issue and retire leave count = 4.
- Assert areset with 2 reads outstanding -> all outputs 0 immediately; after release, late resp_valid is not accepted (resp_ready = 0) and m_resp stays 0.
